// File: rtl/axi_ad9739a_dma_source.sv
`default_nettype none
// ============================================================================
// Module   : axi_ad9739a_dma_source
// Brief    : Packs 64-bit DMA beats into 256-bit DAC words, queues them and
//            pops one word per dac_valid request, flagging underflow.
// Revision : 1.0 - initial release
// ============================================================================
module axi_ad9739a_dma_source #(
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter bit UNF_HOLD        = 1'b0
) (
  input  logic                       dac_div_clk,
  input  logic                       dac_rst,
  input  logic                       s_data_valid,
  output logic                       s_data_ready,
  input  logic [63:0]                s_data,
  input  logic                       s_data_last,
  input  logic                       dac_enable,
  input  logic                       dac_valid,
  output logic [255:0]               dac_ddata,
  output logic                       dac_dunf,
  output logic [FIFO_ADDR_WIDTH:0]   fifo_level,
  output logic [15:0]                unf_count
);

  localparam int                     c_depth      = 2 ** FIFO_ADDR_WIDTH;
  localparam logic [FIFO_ADDR_WIDTH:0]   c_level_full = {1'b1, {FIFO_ADDR_WIDTH{1'b0}}};
  localparam logic [FIFO_ADDR_WIDTH:0]   c_level_one  = {{FIFO_ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [FIFO_ADDR_WIDTH-1:0] c_ptr_one    = {{(FIFO_ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [255:0]                 mem_q [0:c_depth-1];
  logic [FIFO_ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_ADDR_WIDTH:0]     level_q, level_d;
  logic [1:0]                   beat_idx_q, beat_idx_d;
  logic [255:0]                 pack_q, pack_d;
  logic [255:0]                 ddata_q, ddata_d;
  logic                         dunf_q, dunf_d;
  logic [15:0]                  unf_count_q, unf_count_d;

  logic                         w_full;
  logic                         w_empty;
  logic                         w_accept;
  logic                         w_push;
  logic                         w_pop;
  logic                         w_unf;
  logic [255:0]                 w_word;

  assign w_full   = (level_q == c_level_full);
  assign w_empty  = (level_q == '0);
  // Readiness looks only at the registered level, so a pop cannot free a slot
  // for a push in the same cycle when the FIFO is full.
  assign s_data_ready = dac_enable & ~dac_rst & ~w_full;
  assign w_accept = s_data_valid & s_data_ready;
  assign w_push   = w_accept & ((beat_idx_q == 2'd3) | s_data_last);
  assign w_pop    = dac_enable & dac_valid & ~w_empty;
  assign w_unf    = dac_enable & dac_valid & w_empty;

  // Lanes above the current beat are already zero in pack_q, which yields the
  // zero fill for a short burst flushed by s_data_last.
  always_comb begin
    w_word = pack_q;
    case (beat_idx_q)
      2'd0:    w_word[63:0]    = s_data;
      2'd1:    w_word[127:64]  = s_data;
      2'd2:    w_word[191:128] = s_data;
      default: w_word[255:192] = s_data;
    endcase
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    beat_idx_d  = beat_idx_q;
    pack_d      = pack_q;
    ddata_d     = ddata_q;
    dunf_d      = dunf_q;
    unf_count_d = unf_count_q;
    if (!dac_enable) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      beat_idx_d = 2'd0;
      pack_d     = '0;
      ddata_d    = '0;
      dunf_d     = 1'b0;
    end else begin
      if (w_accept) begin
        if (w_push) begin
          beat_idx_d = 2'd0;
          pack_d     = '0;
          wr_ptr_d   = wr_ptr_q + c_ptr_one;
        end else begin
          beat_idx_d = beat_idx_q + 2'd1;
          pack_d     = w_word;
        end
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + c_ptr_one;
        ddata_d  = mem_q[rd_ptr_q];
        dunf_d   = 1'b0;
      end else if (w_unf) begin
        dunf_d  = 1'b1;
        ddata_d = UNF_HOLD ? ddata_q : '0;
        if (unf_count_q != 16'hFFFF) begin
          unf_count_d = unf_count_q + 16'd1;
        end
      end
      case ({w_push, w_pop})
        2'b10:   level_d = level_q + c_level_one;
        2'b01:   level_d = level_q - c_level_one;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge dac_div_clk) begin
    if (dac_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      beat_idx_q  <= 2'd0;
      pack_q      <= '0;
      ddata_q     <= '0;
      dunf_q      <= 1'b0;
      unf_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      beat_idx_q  <= beat_idx_d;
      pack_q      <= pack_d;
      ddata_q     <= ddata_d;
      dunf_q      <= dunf_d;
      unf_count_q <= unf_count_d;
    end
  end

  always_ff @(posedge dac_div_clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= w_word;
    end
  end

  assign dac_ddata  = ddata_q;
  assign dac_dunf   = dunf_q;
  assign fifo_level = level_q;
  assign unf_count  = unf_count_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_ad9739a_dma_source.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_ad9739a_dma_source
// Brief    : Directed + randomized bench with a queue-based reference model;
//            drives a zero-fill and a hold-on-underflow instance in parallel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_ad9739a_dma_source;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, s_valid, s_last, en, dv;
  logic [63:0]  s_data;
  logic         s_ready, s_ready_h;
  logic [255:0] ddata, ddata_h;
  logic         dunf, dunf_h;
  logic [AW:0]  level, level_h;
  logic [15:0]  cnt, cnt_h;

  axi_ad9739a_dma_source #(.FIFO_ADDR_WIDTH(AW), .UNF_HOLD(1'b0)) dut (
    .dac_div_clk(clk), .dac_rst(rst), .s_data_valid(s_valid), .s_data_ready(s_ready),
    .s_data(s_data), .s_data_last(s_last), .dac_enable(en), .dac_valid(dv),
    .dac_ddata(ddata), .dac_dunf(dunf), .fifo_level(level), .unf_count(cnt));

  axi_ad9739a_dma_source #(.FIFO_ADDR_WIDTH(AW), .UNF_HOLD(1'b1)) dut_h (
    .dac_div_clk(clk), .dac_rst(rst), .s_data_valid(s_valid), .s_data_ready(s_ready_h),
    .s_data(s_data), .s_data_last(s_last), .dac_enable(en), .dac_valid(dv),
    .dac_ddata(ddata_h), .dac_dunf(dunf_h), .fifo_level(level_h), .unf_count(cnt_h));

  // Reference model: a word queue, a pending-beat queue and the output regs.
  logic [255:0] m_fifo[$];
  logic [63:0]  m_beats[$];
  logic [255:0] m_dd, m_dd_h;
  logic         m_dunf;
  logic [15:0]  m_cnt;
  bit           do_chk = 1'b1;
  int           n_pass = 0, n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] want);
    n_chk++;
    assert (obs === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    logic         exp_rdy;
    logic [255:0] w;
    exp_rdy = !rst && en && (m_fifo.size() < DEPTH);
    #1;
    if (do_chk) begin
      chk("ready", s_ready, exp_rdy);
      chk("ready_h", s_ready_h, exp_rdy);
    end
    @(posedge clk);
    if (rst) begin
      m_fifo.delete(); m_beats.delete();
      m_dd = '0; m_dd_h = '0; m_dunf = 1'b0; m_cnt = '0;
    end else if (!en) begin
      m_fifo.delete(); m_beats.delete();
      m_dd = '0; m_dd_h = '0; m_dunf = 1'b0;
    end else begin
      if (dv) begin
        if (m_fifo.size() > 0) begin
          w = m_fifo.pop_front();
          m_dd = w; m_dd_h = w; m_dunf = 1'b0;
        end else begin
          m_dunf = 1'b1;
          m_dd   = '0;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
      end
      if (s_valid && exp_rdy) begin
        m_beats.push_back(s_data);
        if (m_beats.size() == 4 || s_last) begin
          w = '0;
          foreach (m_beats[i]) w[64*i +: 64] = m_beats[i];
          m_fifo.push_back(w);
          m_beats.delete();
        end
      end
    end
    #1;
    if (do_chk) begin
      chk("ddata", ddata, m_dd);
      chk("ddata_h", ddata_h, m_dd_h);
      chk("dunf", dunf, m_dunf);
      chk("dunf_h", dunf_h, m_dunf);
      chk("level", level, m_fifo.size());
      chk("unf_count", cnt, m_cnt);
    end
  endtask

  task automatic beat(input logic [63:0] d, input logic last, input logic req);
    s_valid = 1'b1; s_data = d; s_last = last; dv = req;
    tick();
  endtask

  task automatic idle(input logic req);
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; dv = req;
    tick();
  endtask

  initial begin
    logic [255:0] e;
    logic [63:0]  a, b, c;
    rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_last = 1'b0; dv = 1'b0; s_data = '0;
    m_dd = '0; m_dd_h = '0; m_dunf = 1'b0; m_cnt = '0;
    idle(1'b0);
    idle(1'b0);
    rst = 1'b0;
    chk("rst_level", level, 0);
    chk("rst_ddata", ddata, 0);
    chk("rst_cnt", cnt, 0);

    // Ramp word: samples 0..15
    en = 1'b1;
    for (int k = 0; k < 4; k++)
      beat(64'h0003_0002_0001_0000 + 64'h0004_0004_0004_0004 * k, 1'b0, 1'b0);
    chk("t1_level_one", level, 1);
    idle(1'b1);
    e = '0;
    for (int i = 0; i < 16; i++) e[16*i +: 16] = 16'(i);
    chk("t1_ramp_word", ddata, e);
    chk("t1_level_zero", level, 0);

    // Underflow with empty FIFO
    repeat (3) idle(1'b1);
    chk("t2_unf_count", cnt, 3);
    chk("t2_hold_word", ddata_h, e);
    chk("t2_zero_word", ddata, 0);
    idle(1'b0);

    // Fill to full, then pop and concurrent push/pop
    repeat (64) beat({$urandom, $urandom}, 1'b0, 1'b0);
    chk("t3_full_level", level, DEPTH);
    chk("t3_full_ready", s_ready, 0);
    beat({$urandom, $urandom}, 1'b0, 1'b1);
    chk("t3_after_pop_level", level, DEPTH - 1);
    chk("t3_after_pop_ready", s_ready, 1);
    repeat (3) beat({$urandom, $urandom}, 1'b0, 1'b0);
    beat({$urandom, $urandom}, 1'b0, 1'b1);
    chk("t3_pushpop_level", level, DEPTH - 1);

    // Short burst flushed by last
    repeat (15) idle(1'b1);
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom};
    beat(a, 1'b0, 1'b0);
    beat(b, 1'b0, 1'b0);
    beat(c, 1'b1, 1'b0);
    idle(1'b1);
    chk("t4_partial_word", ddata, {64'h0, c, b, a});
    repeat (4) beat({$urandom, $urandom}, 1'b0, 1'b0);
    idle(1'b1);

    // Enable drop discards queued words
    repeat (20) beat({$urandom, $urandom}, 1'b0, 1'b0);
    chk("t5_level_five", level, 5);
    en = 1'b0;
    idle(1'b1);
    chk("t5_level_cleared", level, 0);
    chk("t5_ddata_cleared", ddata, 0);
    en = 1'b1;
    idle(1'b1);
    chk("t5_reenable_unf", dunf, 1);

    // Randomized traffic including enable drops and resets
    for (int n = 0; n < 400; n++) begin
      rst     = ($urandom % 150) == 0;
      en      = ($urandom % 30) != 0;
      s_valid = ($urandom % 4) != 0;
      s_last  = ($urandom % 6) == 0;
      s_data  = {$urandom, $urandom};
      dv      = ($urandom % 3) == 0;
      tick();
    end
    rst = 1'b0; en = 1'b1;

    // Saturating underflow counter
    do_chk = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; dv = 1'b1;
    repeat (70000) tick();
    do_chk = 1'b1;
    idle(1'b1);
    chk("t6_saturated", cnt, 16'hFFFF);
    rst = 1'b1;
    idle(1'b0);
    rst = 1'b0;
    chk("t6_reset_cnt", cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
